// File: rtl/sm_table_pkg.sv
// Shared types and default geometry for the next-state table controller.
package sm_table_pkg;

   localparam int STATE_W_DEF   = 3;
   localparam int IN_W_DEF      = 3;
   localparam int ADDR_W_DEF    = STATE_W_DEF + IN_W_DEF;
   localparam int TBL_DEPTH_DEF = 1 << ADDR_W_DEF;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_PROG
   } fsm_e;

   function automatic int tbl_depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/sm_table_ctrl_btn_sync.sv
// Multi-flop synchroniser for the raw board buttons.
module btn_sync
   import sm_table_pkg::*;
#(
   parameter int WIDTH  = IN_W_DEF,
   parameter int STAGES = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sm_table_ctrl.sv
// Writable next-state table controller: init, host programming, paced run.
// Optional registered readback port enabled by SM_TABLE_READBACK_EN.
module sm_table_ctrl
   import sm_table_pkg::*;
#(
   parameter int STATE_W     = STATE_W_DEF,
   parameter int IN_W        = IN_W_DEF,
   parameter int STEP_DIV    = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [IN_W-1:0]         BTN,
   input  logic                    PROG_REQ,
   input  logic                    PROG_VALID,
   output logic                    PROG_READY,
   input  logic [STATE_W+IN_W-1:0] PROG_ADDR,
   input  logic [STATE_W-1:0]      PROG_DATA,
   output logic [STATE_W-1:0]      STATE_OUT,
   output logic                    BUSY
`ifdef SM_TABLE_READBACK_EN
   ,
   output logic [STATE_W-1:0]      PROG_RDATA
`endif
);

   localparam int ADDR_W = STATE_W + IN_W;
   localparam int DEPTH  = tbl_depth(ADDR_W);
   localparam int CNT_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

   fsm_e               fsm_q, fsm_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STATE_W-1:0] state_q, state_d;
   logic [STATE_W-1:0] tbl_q [DEPTH];
   logic [IN_W-1:0]    btn_s;
   logic               tick;
   logic               we;
   logic [ADDR_W-1:0]  waddr;
   logic [STATE_W-1:0] wdata;

   btn_sync #(
      .WIDTH (IN_W),
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .CLK  (CLK),
      .RESET(RESET),
      .d_i  (BTN),
      .q_o  (btn_s)
   );

   assign tick       = (fsm_q == ST_RUN) && (cnt_q == CNT_LAST);
   assign PROG_READY = !RESET && (fsm_q == ST_PROG) && PROG_REQ;
   assign BUSY       = RESET || (fsm_q != ST_RUN);
   assign STATE_OUT  = state_q;

   always_comb begin
      fsm_d   = fsm_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      we      = 1'b0;
      waddr   = ptr_q;
      wdata   = ptr_q[ADDR_W-1:IN_W];
      unique case (fsm_q)
         ST_INIT: begin
            // self-loop fill: entry holds its own state field
            we    = 1'b1;
            ptr_d = ptr_q + ADDR_W'(1);
            if (&ptr_q) fsm_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) state_d = tbl_q[{state_q, btn_s}];
            if (PROG_REQ) fsm_d = ST_PROG;
         end
         ST_PROG: begin
            we    = PROG_READY && PROG_VALID;
            waddr = PROG_ADDR;
            wdata = PROG_DATA;
            if (!PROG_REQ) fsm_d = ST_RUN;
         end
         default: fsm_d = ST_INIT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fsm_q   <= ST_INIT;
         ptr_q   <= '0;
         cnt_q   <= '0;
         state_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (we && !RESET) tbl_q[waddr] <= wdata;
   end

`ifdef SM_TABLE_READBACK_EN
   logic [STATE_W-1:0] rdata_q;

   // sampled before the same-cycle write lands
   always_ff @(posedge CLK) begin
      if (RESET) rdata_q <= '0;
      else if (fsm_q == ST_PROG) rdata_q <= tbl_q[PROG_ADDR];
   end

   assign PROG_RDATA = rdata_q;
`endif

endmodule

// File: doc/sm_table_ctrl.md
Name: sm_table_ctrl

Overview:
Controller for a writable next-state table of 2^(STATE_W+IN_W) entries. Each entry holds the next state for one {current_state, inputs} address.
- Initialises the table after reset.
- Arbitrates table access between a host programming port and the running machine.
- Paces state advance with a tick divider.
- Synchronises the raw button inputs.
Sits between the board buttons/host loader and the state display logic.

Parameters:
STATE_W, 3, state width in bits
IN_W, 3, number of button inputs; table address = {state, inputs}, ADDR_W = STATE_W+IN_W
STEP_DIV, 1, CLK cycles per state step (1 = every cycle); range 1..2^16
SYNC_STAGES, 2, flops in each button synchroniser (>=2)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
BTN  in  IN_W  raw async buttons; bit IN_W-1 = BTNL, 1 = BTNC, 0 = BTNR
PROG_REQ  in  1  host requests table ownership (level)
PROG_VALID  in  1  write beat valid
PROG_READY  out  1  controller accepts write beat
PROG_ADDR  in  ADDR_W  table address {state, inputs}
PROG_DATA  in  STATE_W  next-state value to write
STATE_OUT  out  STATE_W  current machine state
BUSY  out  1  high in INIT or PROG (machine frozen)

Behaviour:
- Reset is synchronous active-high on CLK, as already decided. RESET forces:
  - FSM to INIT, init pointer 0
  - STATE_OUT=0, PROG_READY=0, BUSY=1
  - tick counter 0, synchroniser flops 0
- FSM states:
  - INIT: one table write per cycle, table[a] = a[ADDR_W-1:IN_W], i.e. self-loop: every state holds regardless of inputs. Pointer walks 0..2^ADDR_W-1, so INIT lasts exactly 2^ADDR_W cycles (64 by default). On the last write, go to RUN. PROG_REQ is ignored in INIT.
  - RUN: BUSY=0. On each tick, STATE_OUT <= table[{STATE_OUT, BTN_sync}]. If PROG_REQ=1, go to PROG next cycle; a tick coinciding with that transition cycle still updates the state.
  - PROG: BUSY=1, PROG_READY=1, STATE_OUT frozen, tick counter held.
    - PROG_VALID & PROG_READY writes table[PROG_ADDR] = PROG_DATA that cycle.
    - PROG_REQ=0 returns to RUN next cycle with PROG_READY=0; a beat presented in that cycle is not accepted.
- Tick: counter counts 0..STEP_DIV-1 in RUN; tick is asserted when the count = STEP_DIV-1, then the counter wraps to 0. STEP_DIV=1 gives a tick every RUN cycle.
- Buttons: SYNC_STAGES-flop synchroniser per bit. A level change on BTN is visible to the lookup SYNC_STAGES cycles later. No debouncing in this block.
- Table read is asynchronous (combinational index); writes are synchronous. RUN never writes, so there is no read/write collision.
- Reset mid-operation: RESET during PROG or RUN aborts, the table is reinitialised through INIT, and all prior programming is lost.
- PROG_ADDR outside range cannot occur (full-width address). PROG_DATA is written unmodified.

Optional Feature:
SM_TABLE_READBACK_EN.
- Defined: adds output PROG_RDATA [STATE_W], registered. Every PROG cycle captures table[PROG_ADDR] as it was before any same-cycle write (read-before-write), valid one cycle later. Holds its value outside PROG. Resets to 0.
- Undefined: the port is absent and no read mux is added.

Decomposition:
- Package sm_table_pkg holds:
  - FSM state enum: INIT, RUN, PROG
  - defaults: STATE_W, IN_W, ADDR_W derivation
  - localparam for the table depth
- One natural sub-module: btn_sync (parameterised width/stages synchroniser), instantiated once with width IN_W.

Test Plan:
- Reset then idle: BUSY=1 for exactly 64 cycles, then 0. STATE_OUT stays 0 under any BTN pattern (self-loop table).
- Program: PROG_REQ=1; write addr 6'b000_100 -> 3'b001 and 6'b001_010 -> 3'b101; drop PROG_REQ. Then:
  - BTN=100: STATE_OUT = 1 within 3 cycles (2 sync + 1 step)
  - BTN=010: STATE_OUT = 5
- Freeze: with the table programmed to advance each tick, raise PROG_REQ. STATE_OUT is held constant for the whole PROG window and PROG_READY=1 one cycle after the request.
- STEP_DIV=4: with the advancing table, STATE_OUT changes exactly every 4th cycle in RUN. The counter does not advance while in PROG.
- Reset mid-PROG after 3 writes: INIT reruns (64 cycles BUSY). Previously programmed entries are back to self-loop, STATE_OUT=0.
- With SM_TABLE_READBACK_EN: write addr 5 -> 3'b110, then present addr 5 with PROG_VALID=0. PROG_RDATA = 3'b110 one cycle later.
